// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
// The optional FETCH_PERF_EN build adds performance counters to instr_fetch_unit.
package instr_fetch_unit_pkg;
    localparam int FETCH_ADDR_W  = 3;
    localparam int FETCH_DATA_W  = 32;
    localparam int FETCH_Q_DEPTH = 2;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, imem (Address/Instruction) and decode (valid/ready, redirect).
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) ();
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Instruction;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output Address, instr_valid, instr_out, instr_pc,
        input  Instruction, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  Address, instr_valid, instr_out, instr_pc,
        output Instruction, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: small FIFO of {pc, instr}; entry 0 is the registered head seen by decode.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_Q_DEPTH,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr,
    output logic [OCC_W-1:0]  occupancy
);
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] shift_pc    [DEPTH];
    logic [DATA_W-1:0] shift_instr [DEPTH];
    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  wr_slot;

    // After a pop everything moves down one slot, so the new word lands at occ-pop.
    assign wr_slot = occ_reg - OCC_W'(pop);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (gi < DEPTH - 1) begin : g_shift
            assign shift_pc[gi]    = pc_mem[gi+1];
            assign shift_instr[gi] = instr_mem[gi+1];
        end else begin : g_last
            assign shift_pc[gi]    = pc_mem[gi];
            assign shift_instr[gi] = instr_mem[gi];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pc_mem[gi]    <= '0;
                instr_mem[gi] <= '0;
            end else if (!flush) begin
                if (push && wr_slot == OCC_W'(gi)) begin
                    pc_mem[gi]    <= push_pc;
                    instr_mem[gi] <= push_instr;
                end else if (pop) begin
                    pc_mem[gi]    <= shift_pc[gi];
                    instr_mem[gi] <= shift_instr[gi];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        occ_reg <= '0;
        else if (flush) occ_reg <= '0;
        else            occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
    end

    assign head_pc    = pc_mem[0];
    assign head_instr = instr_mem[0];
    assign occupancy  = occ_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, issues imem reads only when the 2-entry queue has room, handles redirects.
// Build with FETCH_PERF_EN defined to add the perf_fetched / perf_stall saturating counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int DATA_W   = FETCH_DATA_W,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
`ifdef FETCH_PERF_EN
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_stall,
`endif
    instr_fetch_unit_if.master  bus
);
    localparam int OCC_W = $clog2(FETCH_Q_DEPTH + 1);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, inflight_pc_reg;
    logic              inflight_reg;
    logic [OCC_W-1:0]  occupancy;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;
    logic              instr_valid, pop, push, issue;
    logic [OCC_W:0]    load, capacity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_BOOT;
        else       state_reg <= state_next;
    end

    // Room = depth - occupancy - inflight + pop, compared without going negative.
    always_comb begin
        state_next = ST_RUN;
        load       = {1'b0, occupancy} + (OCC_W+1)'(inflight_reg);
        capacity   = (OCC_W+1)'(FETCH_Q_DEPTH) + (OCC_W+1)'(pop);
        issue      = 1'b0;
        if (state_reg == ST_RUN && !bus.redirect_valid && load < capacity)
            issue = 1'b1;
    end

    assign instr_valid = (occupancy != '0);
    assign pop         = instr_valid && bus.instr_ready;
    assign push        = inflight_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg          <= ADDR_W'(RESET_PC);
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else if (bus.redirect_valid) begin
            pc_reg       <= bus.redirect_pc;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg          <= pc_reg + ADDR_W'(1);
                inflight_pc_reg <= pc_reg;
            end
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FETCH_Q_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_pc    (inflight_pc_reg),
        .push_instr (bus.Instruction),
        .pop        (pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .occupancy  (occupancy)
    );

    assign bus.Address     = pc_reg;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_out   = head_instr;
    assign bus.instr_pc    = head_pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (instr_valid && !bus.instr_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif
endmodule
